sdram_bist: RTL and testbench
=============================

Name: sdram_bist

Overview:
Parametrised built-in self-test engine for the SDRAM controller user port. On a start pulse it writes a selectable data pattern over a configurable address window, then reads the window back and compares every word in order. It reports an error count, the first failing address and a read-timeout flag. It sits between the debug/control register block and the SDRAM controller, and replaces ad-hoc single-address write/read exercisers.

Parameters:
DATA_W, 16, data width of controller port and pattern
ADDR_W, 26, word address width
MAX_OUTST, 4, maximum read commands in flight (1..15)
TIMEOUT, 1024, cycles without rd_valid while reads are outstanding before abort
LFSR_TAPS, 16'hB400, Galois LFSR feedback mask (low DATA_W bits used)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; starts a test when in IDLE or DONE
loop_en  in  1  when 1, restart automatically after a passing pass, seed+1
pattern_sel  in  2  0=increment, 1=inverted increment, 2=LFSR, 3=address echo
seed  in  DATA_W  pattern seed, sampled at start
base_addr  in  ADDR_W  first word address, sampled at start
length  in  ADDR_W  number of words (0 treated as 1), sampled at start
cmd_valid  out  1  command request to controller
cmd_ready  in  1  controller accepts command when cmd_valid&cmd_ready
cmd_wr  out  1  1=write, 0=read
cmd_addr  out  ADDR_W  command address
cmd_wdata  out  DATA_W  write data
rd_valid  in  1  read data valid, returned in command order
rd_data  in  DATA_W  read data
busy  out  1  high in WRITE/READ
done  out  1  high in DONE
pass  out  1  valid in DONE: err_count==0 and no timeout
timeout  out  1  read timeout occurred
err_count  out  16  mismatches, saturating at 16'hFFFF
first_err_addr  out  ADDR_W  address of first mismatch
pass_count  out  16  completed passing loops, wrapping

Behaviour:
- Reset: every output 0; state IDLE; internal counters 0.
- The reset is asynchronous and may occur mid-operation. Outstanding controller reads are then abandoned. The controller shares rst_n.
- States:
  - IDLE -> WRITE on start.
  - WRITE -> READ after the last write handshake.
  - READ -> DONE when all words are compared, or on timeout.
  - DONE -> WRITE on start.
  - DONE -> WRITE automatically one cycle after entry if loop_en=1 and pass=1; seed increments by 1 and pass_count increments.
- Start actions:
  - Sample seed/base_addr/length.
  - Clear err_count, first_err_addr and timeout.
  - Start ignored while busy.
- Pattern p(i) for word index i:
  - mode0: seed+i mod 2^DATA_W.
  - mode1: ~(seed+i).
  - mode2: LFSR state; starts at seed (0 replaced by 1), advances one step per word (shift right, XOR LFSR_TAPS if LSB was 1).
  - mode3: low DATA_W bits of address XOR seed.
  - Write and read phases each keep their own generator, restarted at index 0.
- WRITE:
  - cmd_valid=1, cmd_wr=1, cmd_addr=base_addr+i, cmd_wdata=p(i).
  - Outputs hold stable until the handshake; i advances only on the handshake.
  - Address wraps modulo 2^ADDR_W.
- READ issue side:
  - cmd_valid=1, cmd_wr=0 while issued<length and outstanding<MAX_OUTST.
  - outstanding +1 on handshake, -1 on rd_valid; both in one cycle leave it unchanged.
- READ compare side:
  - On rd_valid, compare rd_data to expected p(j), then j+1.
  - On mismatch, err_count+1 (saturating). first_err_addr=base_addr+j only on the first mismatch.
  - rd_valid with outstanding==0 is ignored.
- Timeout:
  - The counter resets on every rd_valid and counts while outstanding>0.
  - At TIMEOUT: set timeout=1, go to DONE, drop cmd_valid.
- DONE:
  - cmd_valid=0, done=1, pass=(err_count==0 && !timeout).
  - Result registers hold until the next start.
- No combinational path from cmd_ready/rd_valid to outputs; all outputs are registered.

Test Plan:
- Ideal controller (ready=1, read latency 3), mode0, seed=0x0010, base=0x100, length=8 -> writes 0x0010..0x0017 to 0x100..0x107; done=1, pass=1, err_count=0.
- Same setup, controller corrupts the word at 0x103 and 0x105 -> err_count=2, first_err_addr=0x103, pass=0.
- Random cmd_ready stalls, latency 7, MAX_OUTST=4, mode2 seed=0 -> never more than 4 reads in flight; LFSR starts at 1; pass=1.
- Controller drops the 5th read response -> after 1024 idle cycles timeout=1, done=1, pass=0.
- base=0x3FFFFFE, length=4 -> addresses 0x3FFFFFE, 0x3FFFFFF, 0x0, 0x1.
- loop_en=1 with a clean memory -> pass_count increments to 3 after three passes, each pass seed+1; rst_n asserted mid-READ -> all outputs 0, IDLE.

Source files
------------

// File: rtl/sdram_bist.sv
// sdram_bist: built-in self-test engine for the SDRAM controller user port.
// A start pulse writes a pattern over [base_addr, base_addr+length) and then
// reads the window back, comparing each returned word in order.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, loop_en         test launch pulse, auto-restart after a passing run
//   pattern_sel, seed      pattern mode and seed (sampled at start)
//   base_addr, length      address window (sampled at start, length 0 -> 1)
//   cmd_*                  command channel to the controller (valid/ready)
//   rd_valid, rd_data      in-order read return from the controller
//   busy, done, pass       status
//   timeout, err_count, first_err_addr, pass_count   results
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_WRITE | issuing write commands, one per handshake
// S_READ  | issuing reads (bounded in flight) and comparing returned data
// S_DONE  | results valid; start or a passing loop relaunches
module sdram_bist #(
    parameter int          DATA_W    = 16,
    parameter int          ADDR_W    = 26,
    parameter int          MAX_OUTST = 4,
    parameter int          TIMEOUT   = 1024,
    parameter logic [63:0] LFSR_TAPS = 64'hB400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              loop_en,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] seed,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [15:0]       pass_count
);

    localparam int OW = 4;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] TAPS = LFSR_TAPS[DATA_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] x);
        lfsr_step = (x >> 1) ^ (x[0] ? TAPS : '0);
    endfunction

    function automatic logic [DATA_W-1:0] pat_f(input logic [1:0]        mode,
                                                input logic [DATA_W-1:0] sd,
                                                input logic [ADDR_W-1:0] idx,
                                                input logic [DATA_W-1:0] lf,
                                                input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] inc;
        inc = sd + DATA_W'(idx);
        case (mode)
            2'd0:    pat_f = inc;
            2'd1:    pat_f = ~inc;
            2'd2:    pat_f = lf;
            default: pat_f = DATA_W'(addr) ^ sd;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
    logic [DATA_W-1:0] wr_lfsr_q, wr_lfsr_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic [DATA_W-1:0] rd_lfsr_q, rd_lfsr_d;
    logic [ADDR_W-1:0] iss_q, iss_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic [15:0]       pcnt_q, pcnt_d;

    logic              launch, wr_hs, rd_hs, rd_acc, tmo_hit;
    logic [DATA_W-1:0] l_seed, l_lfsr, exp_data;
    logic [ADDR_W-1:0] l_base, l_len, rd_addr;
    logic [1:0]        l_mode;

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        base_d      = base_q;
        len_d       = len_q;
        mode_d      = mode_q;
        wr_idx_d    = wr_idx_q;
        wr_lfsr_d   = wr_lfsr_q;
        rd_idx_d    = rd_idx_q;
        rd_lfsr_d   = rd_lfsr_q;
        iss_d       = iss_q;
        outst_d     = outst_q;
        tmo_d       = tmo_q;
        cmd_valid_d = cmd_valid_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        timeout_d   = timeout_q;
        err_d       = err_q;
        first_d     = first_q;
        pcnt_d      = pcnt_q;
        launch      = 1'b0;
        tmo_hit     = 1'b0;
        l_seed      = seed;
        l_base      = base_addr;
        l_len       = (length == '0) ? ADDR_W'(1) : length;
        l_mode      = pattern_sel;
        l_lfsr      = '0;
        exp_data    = '0;
        rd_addr     = base_q + rd_idx_q;
        wr_hs       = cmd_valid_q & cmd_ready & cmd_wr_q;
        rd_hs       = cmd_valid_q & cmd_ready & ~cmd_wr_q;
        rd_acc      = (state_q == S_READ) && rd_valid && (outst_q != '0);

        case (state_q)
            S_IDLE: launch = start;
            S_WRITE: begin
                if (wr_hs) begin
                    if (wr_idx_q == len_q - ADDR_W'(1)) begin
                        state_d     = S_READ;
                        cmd_wr_d    = 1'b0;
                        cmd_addr_d  = base_q;
                        cmd_wdata_d = '0;
                    end else begin
                        wr_idx_d    = wr_idx_q + ADDR_W'(1);
                        wr_lfsr_d   = lfsr_step(wr_lfsr_q);
                        cmd_addr_d  = base_q + wr_idx_d;
                        cmd_wdata_d = pat_f(mode_q, seed_q, wr_idx_d, wr_lfsr_d, cmd_addr_d);
                    end
                end
            end
            S_READ: begin
                outst_d = outst_q + {{(OW-1){1'b0}}, rd_hs} - {{(OW-1){1'b0}}, rd_acc};
                if (rd_hs) begin
                    iss_d      = iss_q + ADDR_W'(1);
                    cmd_addr_d = base_q + iss_d;
                end
                if (rd_acc) begin
                    exp_data = pat_f(mode_q, seed_q, rd_idx_q, rd_lfsr_q, rd_addr);
                    if (rd_data != exp_data) begin
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        if (err_q == 16'd0)    first_d = rd_addr;
                    end
                    rd_idx_d  = rd_idx_q + ADDR_W'(1);
                    rd_lfsr_d = lfsr_step(rd_lfsr_q);
                end
                // Idle timer only runs while reads are owed to us.
                if (rd_valid || outst_q == '0)
                    tmo_d = TW'(TIMEOUT);
                else if (tmo_q == TW'(1))
                    tmo_hit = 1'b1;
                else
                    tmo_d = tmo_q - TW'(1);

                if (tmo_hit) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else if (rd_acc && rd_idx_q == len_q - ADDR_W'(1)) begin
                    state_d = S_DONE;
                end
                cmd_valid_d = (state_d == S_READ) && (iss_d < len_q) &&
                              (outst_d < OW'(MAX_OUTST));
            end
            S_DONE: begin
                if (start) begin
                    launch = 1'b1;
                end else if (loop_en && pass_q) begin
                    launch = 1'b1;
                    l_seed = seed_q + DATA_W'(1);
                    l_base = base_q;
                    l_len  = len_q;
                    l_mode = mode_q;
                    pcnt_d = pcnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            l_lfsr      = (l_seed == '0) ? DATA_W'(1) : l_seed;
            state_d     = S_WRITE;
            seed_d      = l_seed;
            base_d      = l_base;
            len_d       = l_len;
            mode_d      = l_mode;
            wr_idx_d    = '0;
            rd_idx_d    = '0;
            wr_lfsr_d   = l_lfsr;
            rd_lfsr_d   = l_lfsr;
            iss_d       = '0;
            outst_d     = '0;
            tmo_d       = TW'(TIMEOUT);
            err_d       = '0;
            first_d     = '0;
            timeout_d   = 1'b0;
            cmd_valid_d = 1'b1;
            cmd_wr_d    = 1'b1;
            cmd_addr_d  = l_base;
            cmd_wdata_d = pat_f(l_mode, l_seed, '0, l_lfsr, l_base);
        end

        busy_d = (state_d == S_WRITE) || (state_d == S_READ);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == 16'd0) && !timeout_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            seed_q      <= '0;
            base_q      <= '0;
            len_q       <= '0;
            mode_q      <= '0;
            wr_idx_q    <= '0;
            wr_lfsr_q   <= '0;
            rd_idx_q    <= '0;
            rd_lfsr_q   <= '0;
            iss_q       <= '0;
            outst_q     <= '0;
            tmo_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= '0;
            first_q     <= '0;
            pcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            base_q      <= base_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            wr_idx_q    <= wr_idx_d;
            wr_lfsr_q   <= wr_lfsr_d;
            rd_idx_q    <= rd_idx_d;
            rd_lfsr_q   <= rd_lfsr_d;
            iss_q       <= iss_d;
            outst_q     <= outst_d;
            tmo_q       <= tmo_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
            first_q     <= first_d;
            pcnt_q      <= pcnt_d;
        end
    end

    assign cmd_valid      = cmd_valid_q;
    assign cmd_wr         = cmd_wr_q;
    assign cmd_addr       = cmd_addr_q;
    assign cmd_wdata      = cmd_wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign pass_count     = pcnt_q;

endmodule

// File: tb/tb_sdram_bist.sv
// Testbench for sdram_bist: behavioural SDRAM controller model (configurable
// latency, ready stalls, word corruption, dropped response) plus directed
// scenario tasks with hand-computed expectations.
module tb_sdram_bist;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, loop_en;
    logic [1:0]  pattern_sel;
    logic [15:0] seed;
    logic [25:0] base_addr, length;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [25:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count, pass_count;
    logic [25:0] first_err_addr;

    always #5 clk = ~clk;

    sdram_bist dut (
        .clk(clk), .rst_n(rst_n), .start(start), .loop_en(loop_en),
        .pattern_sel(pattern_sel), .seed(seed), .base_addr(base_addr), .length(length),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_addr(first_err_addr), .pass_count(pass_count)
    );

    int checks = 0;
    int passed = 0;

    // controller model state
    logic [15:0] mem [logic [25:0]];
    logic [25:0] rq_addr[$];
    int          rq_due[$];
    logic [25:0] wlog_a[$];
    logic [15:0] wlog_d[$];
    logic [25:0] rlog_a[$];
    int          ncyc = 0;
    int          lat = 3;
    bit          stall_en = 0;
    bit          corrupt_en = 0;
    logic [25:0] bad0 = '0, bad1 = '0;
    int          drop_n = 0;
    int          resp_n = 0;
    int          inflight = 0;
    int          peak = 0;
    int          hold_viol = 0;
    int          last_rv_cyc = -1;
    int          done_cyc = -1;

    // Everything is driven and observed on the falling edge; handshakes and
    // read returns decided here take effect at the following rising edge.
    initial begin
        logic        held;
        logic        held_wr;
        logic [25:0] held_a, a;
        logic [15:0] held_d;
        held = 0; held_wr = 0; held_a = '0; held_d = '0;
        cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                rq_addr.delete(); rq_due.delete();
                inflight = 0; resp_n = 0; held = 0;
                cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
            end else begin
                if (done && done_cyc < 0) done_cyc = ncyc;
                if (held && cmd_valid) begin
                    if (cmd_addr !== held_a || cmd_wr !== held_wr ||
                        (held_wr && cmd_wdata !== held_d))
                        hold_viol++;
                end
                cmd_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                held    = cmd_valid && !cmd_ready;
                held_a  = cmd_addr;
                held_d  = cmd_wdata;
                held_wr = cmd_wr;
                if (cmd_valid && cmd_ready) begin
                    if (cmd_wr) begin
                        mem[cmd_addr] = cmd_wdata;
                        wlog_a.push_back(cmd_addr);
                        wlog_d.push_back(cmd_wdata);
                    end else begin
                        rq_addr.push_back(cmd_addr);
                        rq_due.push_back(ncyc + lat);
                        rlog_a.push_back(cmd_addr);
                        inflight++;
                    end
                end
                rd_valid = 1'b0;
                rd_data  = '0;
                if (rq_due.size() > 0 && rq_due[0] <= ncyc) begin
                    a = rq_addr.pop_front();
                    void'(rq_due.pop_front());
                    resp_n++;
                    if (resp_n != drop_n) begin
                        rd_valid = 1'b1;
                        rd_data  = mem.exists(a) ? mem[a] : 16'h0000;
                        if (corrupt_en && (a == bad0 || a == bad1)) rd_data = rd_data ^ 16'h0100;
                        last_rv_cyc = ncyc;
                        inflight--;
                    end
                end
                if (inflight > peak) peak = inflight;
            end
        end
    end

    task automatic clear_logs();
        wlog_a.delete(); wlog_d.delete(); rlog_a.delete();
        peak = 0; hold_viol = 0; last_rv_cyc = -1; done_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; loop_en = 1'b0;
        repeat (3) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic run(input logic [1:0] mode, input logic [15:0] sd, input logic [25:0] b,
                       input logic [25:0] len, input int budget, output bit ok);
        @(negedge clk);
        pattern_sel = mode; seed = sd; base_addr = b; length = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cmd_valid, cmd_wr, busy, done, pass, timeout} !== 6'b0)
            $display("FAIL reset_flags: got %b required 000000", {cmd_valid, cmd_wr, busy, done, pass, timeout});
        else passed++;
        checks++;
        if (cmd_addr !== 26'h0 || cmd_wdata !== 16'h0)
            $display("FAIL reset_cmd: addr %h data %h required 0", cmd_addr, cmd_wdata);
        else passed++;
        checks++;
        if (err_count !== 16'h0 || first_err_addr !== 26'h0 || pass_count !== 16'h0)
            $display("FAIL reset_results: err %h first %h pcnt %h required 0", err_count, first_err_addr, pass_count);
        else passed++;
    endtask

    task automatic test_basic_inc();
        bit ok;
        do_reset();
        lat = 3; stall_en = 0; corrupt_en = 0; drop_n = 0;
        run(2'd0, 16'h0010, 26'h100, 26'd8, 300, ok);
        checks++;
        if (!ok) $display("FAIL basic_done: done not seen within budget"); else passed++;
        checks++;
        if (wlog_a.size() !== 8) $display("FAIL basic_nwrites: got %0d required 8", wlog_a.size()); else passed++;
        for (int i = 0; i < wlog_a.size() && i < 8; i++) begin
            logic [25:0] ea;
            logic [15:0] ed;
            ea = 26'h100 + 26'(i);
            ed = 16'h0010 + 16'(i);
            checks++;
            if (wlog_a[i] !== ea || wlog_d[i] !== ed)
                $display("FAIL basic_write%0d: got %h/%h required %h/%h", i, wlog_a[i], wlog_d[i], ea, ed);
            else passed++;
        end
        checks++;
        if (rlog_a.size() !== 8 || rlog_a[0] !== 26'h100 || rlog_a[7] !== 26'h107)
            $display("FAIL basic_reads: n %0d first %h last %h required 8/100/107", rlog_a.size(), rlog_a[0], rlog_a[rlog_a.size()-1]);
        else passed++;
        checks++;
        if ({busy, done, pass, timeout} !== 4'b0110 || err_count !== 16'd0)
            $display("FAIL basic_status: busy/done/pass/to %b err %0d required 0110 0", {busy, done, pass, timeout}, err_count);
        else passed++;
    endtask

    task automatic test_corrupt();
        bit ok;
        do_reset();
        lat = 3; stall_en = 0; corrupt_en = 1; bad0 = 26'h103; bad1 = 26'h105; drop_n = 0;
        run(2'd0, 16'h0010, 26'h100, 26'd8, 300, ok);
        checks++;
        if (!ok) $display("FAIL corrupt_done: done not seen within budget"); else passed++;
        checks++;
        if (err_count !== 16'd2) $display("FAIL corrupt_err: got %0d required 2", err_count); else passed++;
        checks++;
        if (first_err_addr !== 26'h103) $display("FAIL corrupt_first: got %h required 103", first_err_addr); else passed++;
        checks++;
        if (pass !== 1'b0 || timeout !== 1'b0) $display("FAIL corrupt_pass: pass %b to %b required 0 0", pass, timeout); else passed++;
    endtask

    // Restart directly from DONE with a clean memory: results must clear.
    task automatic test_back_to_back();
        bit ok;
        corrupt_en = 0;
        clear_logs();
        run(2'd1, 16'h0010, 26'h200, 26'd3, 300, ok);
        checks++;
        if (!ok) $display("FAIL b2b_done: done not seen within budget"); else passed++;
        checks++;
        if (wlog_d.size() !== 3 || wlog_d[0] !== 16'hFFEF || wlog_d[1] !== 16'hFFEE || wlog_d[2] !== 16'hFFED)
            $display("FAIL b2b_mode1_data: n %0d d0 %h required 3 FFEF FFEE FFED", wlog_d.size(), wlog_d[0]);
        else passed++;
        checks++;
        if (pass !== 1'b1 || err_count !== 16'd0 || first_err_addr !== 26'h0)
            $display("FAIL b2b_cleared: pass %b err %0d first %h required 1 0 0", pass, err_count, first_err_addr);
        else passed++;
        clear_logs();
        run(2'd0, 16'hABCD, 26'h10, 26'd0, 300, ok);
        checks++;
        if (!ok || wlog_d.size() !== 1 || wlog_d[0] !== 16'hABCD || wlog_a[0] !== 26'h10 || pass !== 1'b1)
            $display("FAIL len0: ok %0d n %0d data %h pass %b required 1 1 ABCD 1", ok, wlog_d.size(), wlog_d[0], pass);
        else passed++;
    endtask

    task automatic test_stall_lfsr();
        bit ok;
        do_reset();
        lat = 7; stall_en = 1; corrupt_en = 0; drop_n = 0;
        run(2'd2, 16'h0000, 26'h40, 26'd16, 1000, ok);
        checks++;
        if (!ok) $display("FAIL lfsr_done: done not seen within budget"); else passed++;
        checks++;
        if (wlog_d.size() !== 16 || wlog_d[0] !== 16'h0001 || wlog_d[1] !== 16'hB400 || wlog_d[2] !== 16'h5A00)
            $display("FAIL lfsr_seq: n %0d %h %h %h required 16 0001 B400 5A00", wlog_d.size(), wlog_d[0], wlog_d[1], wlog_d[2]);
        else passed++;
        checks++;
        if (peak > 4 || peak < 3) $display("FAIL outst_peak: got %0d required 3..4", peak); else passed++;
        checks++;
        if (hold_viol !== 0) $display("FAIL cmd_hold: got %0d changes while stalled required 0", hold_viol); else passed++;
        checks++;
        if (pass !== 1'b1 || err_count !== 16'd0) $display("FAIL lfsr_pass: pass %b err %0d required 1 0", pass, err_count); else passed++;
        stall_en = 0;
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        lat = 3; stall_en = 0; corrupt_en = 0; drop_n = 5;
        run(2'd0, 16'h0010, 26'h100, 26'd8, 1500, ok);
        checks++;
        if (!ok) $display("FAIL to_done: done not seen within budget"); else passed++;
        checks++;
        if (timeout !== 1'b1 || pass !== 1'b0) $display("FAIL to_flag: to %b pass %b required 1 0", timeout, pass); else passed++;
        checks++;
        if (err_count !== 16'd3 || first_err_addr !== 26'h104)
            $display("FAIL to_errs: err %0d first %h required 3 104", err_count, first_err_addr);
        else passed++;
        checks++;
        if (done_cyc - last_rv_cyc < 1024 || done_cyc - last_rv_cyc > 1026)
            $display("FAIL to_span: got %0d cycles required 1024..1026", done_cyc - last_rv_cyc);
        else passed++;
        drop_n = 0;
    endtask

    task automatic test_wrap_mode3();
        bit ok;
        do_reset();
        lat = 3;
        run(2'd3, 16'h00FF, 26'h3FFFFFE, 26'd4, 300, ok);
        checks++;
        if (!ok || pass !== 1'b1) $display("FAIL wrap_pass: ok %0d pass %b required 1 1", ok, pass); else passed++;
        checks++;
        if (wlog_a.size() !== 4 || wlog_a[0] !== 26'h3FFFFFE || wlog_a[1] !== 26'h3FFFFFF ||
            wlog_a[2] !== 26'h0 || wlog_a[3] !== 26'h1)
            $display("FAIL wrap_addr: n %0d a2 %h a3 %h required 4 0 1", wlog_a.size(), wlog_a[2], wlog_a[3]);
        else passed++;
        checks++;
        if (wlog_d.size() !== 4 || wlog_d[0] !== 16'hFF01 || wlog_d[1] !== 16'hFF00 ||
            wlog_d[2] !== 16'h00FF || wlog_d[3] !== 16'h00FE)
            $display("FAIL wrap_data: n %0d d0 %h d3 %h required 4 FF01 00FE", wlog_d.size(), wlog_d[0], wlog_d[3]);
        else passed++;
    endtask

    task automatic test_loop_and_reset();
        bit ok;
        bit in_read;
        do_reset();
        lat = 3;
        loop_en = 1'b1;
        run(2'd0, 16'h0100, 26'h800, 26'd4, 300, ok);
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            if (pass_count == 16'd3) begin ok = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) $display("FAIL loop_count: pass_count %0d never reached 3", pass_count); else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if (wlog_d.size() < 13 || wlog_d[0] !== 16'h0100 || wlog_d[4] !== 16'h0101 ||
            wlog_d[8] !== 16'h0102 || wlog_d[12] !== 16'h0103 || wlog_a[12] !== 26'h800)
            $display("FAIL loop_seed: n %0d d4 %h d12 %h required >=13 0101 0103", wlog_d.size(), wlog_d[4], wlog_d[12]);
        else passed++;
        in_read = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy && cmd_valid && !cmd_wr) begin in_read = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!in_read) $display("FAIL loop_read: read phase not seen within budget"); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_valid, busy, done, pass, timeout} !== 5'b0 || pass_count !== 16'd0 ||
            err_count !== 16'd0 || cmd_addr !== 26'h0)
            $display("FAIL midreset: flags %b pcnt %0d err %0d addr %h required 0", {cmd_valid, busy, done, pass, timeout}, pass_count, err_count, cmd_addr);
        else passed++;
        loop_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_after_reset: busy %b valid %b done %b required 0", busy, cmd_valid, done);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; loop_en = 1'b0;
        pattern_sel = '0; seed = '0; base_addr = '0; length = '0;
        test_reset();
        test_basic_inc();
        test_corrupt();
        test_back_to_back();
        test_stall_lfsr();
        test_timeout();
        test_wrap_mode3();
        test_loop_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
